// File: rtl/wb_mem_unit.sv
// Final-stage memory-access / write-back unit: byte-enabled local data memory,
// sign/zero-extending loads with MEM_LAT latency, ALU write-back forwarding.
module wb_mem_unit #(
  parameter int MEM_DEPTH = 1024,
  parameter int MEM_LAT   = 2,
  parameter int REG_AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [REG_AW-1:0] rd,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [31:0]       wb_data,
  output logic              fault
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ld_done;

  logic [3:0][7:0]  mem [MEM_DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             is_mem, bad, accept;
  logic             do_store, do_load, do_alu;
  logic [3:0]       be;
  logic [3:0][7:0]  wdata;

  logic [IDX_W-1:0]  ld_idx;
  logic [1:0]        ld_lane;
  logic [1:0]        ld_size;
  logic              ld_uns;
  logic [REG_AW-1:0] ld_rd;
  logic [31:0]       ld_word, ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Upper address bits beyond the memory span are deliberately ignored (wrap).
  logic unused_addr;
  assign unused_addr = ^alu_result[31:IDX_W+2];

  assign idx    = alu_result[IDX_W+1:2];
  assign lane   = alu_result[1:0];
  assign is_mem = mem_read || mem_write;
  assign bad    = (mem_read && mem_write) ||
                  (is_mem && ((size == 2'b11) ||
                              (size == SZ_HALF && lane[0]) ||
                              (size == SZ_WORD && lane != 2'b00)));

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign do_store = accept && mem_write && !bad;
  assign do_load  = accept && mem_read && !bad;
  assign do_alu   = accept && !is_mem && reg_write;

  // Replicate store data across lanes; the byte enables pick which lanes land.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    be    = 4'b0000;
    wdata = store_data;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wdata = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // NOTE: the data memory has no reset; clearing it would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= wdata[i];
      end
    end
  end

  // No store can be accepted while a load waits, so reading at completion is safe.
  assign ld_word = mem[ld_idx];
  assign ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
  assign ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_ext = ld_word;
    case (ld_size)
      SZ_BYTE: ld_ext = {{24{ld_byte[7] & ~ld_uns}}, ld_byte};
      SZ_HALF: ld_ext = {{16{ld_half[15] & ~ld_uns}}, ld_half};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ld_done    = 1'b0;
    case (state)
      IDLE: begin
        if (do_load) begin
          state_next = LOAD_WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      LOAD_WAIT: begin
        if (cnt == '0) begin
          ld_done    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      fault    <= 1'b0;
      ld_idx   <= '0;
      ld_lane  <= '0;
      ld_size  <= '0;
      ld_uns   <= 1'b0;
      ld_rd    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= state_next;
      cnt      <= cnt_next;
      fault    <= accept && bad;
      wb_valid <= 1'b0;
      if (do_load) begin
        ld_idx  <= idx;
        ld_lane <= lane;
        ld_size <= size;
        ld_uns  <= ld_unsigned;
        ld_rd   <= rd;
      end
      // ALU accepts happen only in IDLE and load completion only in LOAD_WAIT.
      if (do_alu && rd != '0) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd;
        wb_data  <= alu_result;
      end else if (ld_done && ld_rd != '0) begin
        wb_valid <= 1'b1;
        wb_rd    <= ld_rd;
        wb_data  <= ld_ext;
      end
    end
  end

endmodule

// File: doc/wb_mem_unit.md
# wb_mem_unit

Parametrised memory-access and write-back unit for the core's final pipeline stage, the successor to the single-cycle write stage. It accepts one instruction result per handshake. Stores commit byte/halfword/word data into a local byte-enabled data memory. Loads return sign- or zero-extended data after a configurable memory latency. ALU results are forwarded to the register file write port, and misaligned or illegal accesses are flagged instead of executed.

## Interface
Parameters:
- MEM_DEPTH, 1024: data memory depth in 32-bit words; power of two, ≥ 4.
- MEM_LAT, 2: load latency in cycles from accept to write-back; range 1–8.
- REG_AW, 5: register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- reg_write  in  1  ALU result write-back request; ignored when mem_read or mem_write is set.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- ld_unsigned  in  1  zero-extend load data instead of sign-extending it.
- rd  in  REG_AW  destination register.
- alu_result  in  32  byte address for memory ops; write-back value for ALU ops.
- store_data  in  32  store data, right-aligned.
- wb_valid  out  1  one-cycle write-back strobe.
- wb_rd  out  REG_AW  write-back register address.
- wb_data  out  32  write-back data.
- fault  out  1  one-cycle pulse on a misaligned or illegal request.

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Word index: alu_result[log2(MEM_DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·MEM_DEPTH bytes. Byte lane: alu_result[1:0].
- Fault conditions, checked at accept. No memory write and no wb_valid; fault pulses in the next cycle; the state machine stays in IDLE. A request faults if any of the following holds:
  - mem_read && mem_write;
  - size == 11 on a memory op;
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 00.
- Store: writes the low byte/half/word of store_data into the addressed lanes only; the other lanes are preserved. Commits at the accept edge. Produces no write-back.
- Load: reads the full word, then selects the lane and extends it to 32 bits. Byte: bits [7:0] of the selected lane, sign bit 7. Half: lane 0 or 2, sign bit 15. Word: unchanged.
- ALU op (reg_write only): wb_data = alu_result.
- rd == 0: the request is processed normally, but wb_valid is suppressed. Memory side effects still occur.
- A request with none of mem_read, mem_write, reg_write set is accepted and discarded.
- State machine:
  - IDLE (in_ready = 1): an accepted load moves to LOAD_WAIT and loads the latency counter with MEM_LAT−1. All other requests stay in IDLE.
  - LOAD_WAIT (in_ready = 0): the counter decrements each cycle. At 0, the unit asserts the load write-back in that cycle and returns to IDLE.
  - With MEM_LAT = 1, LOAD_WAIT lasts exactly one cycle. That cycle is the write-back cycle.
- Memory contents are not reset. Contents are undefined until written.

## Timing
- Reset values: wb_valid 0, wb_rd 0, wb_data 0, fault 0, state IDLE, in_ready 1.
- ALU write-back: wb_valid is high in the cycle after accept. Throughput is 1 per cycle.
- Store: no output. The next request is accepted in the next cycle. A load accepted in the following cycle observes the stored data.
- Load: wb_valid is high exactly MEM_LAT cycles after the accept edge. in_ready is low for MEM_LAT cycles. The next request is accepted in the wb_valid cycle at the earliest.
- wb_rd and wb_data are registered. They hold their last value when wb_valid = 0.
- fault and wb_valid are never high together.
- Reset asserted mid-load aborts the load: no wb_valid after reset release, and in_ready = 1 immediately.
- Stores to the same word in back-to-back cycles apply in order. Byte lanes merge correctly.

## Test plan
- Reset, then ALU ops rd=3 value 0xDEADBEEF followed by rd=0 value 5, back-to-back → wb_valid in the next cycle with rd 3 / 0xDEADBEEF. No wb_valid for rd=0. in_ready stays 1.
- Store word 0x11223344 @0x10, then store byte 0xAA @0x12, then load word @0x10, MEM_LAT=2 → wb_data 0x11AA3344 exactly 2 cycles after the load accept. in_ready is low for 2 cycles.
- Load byte @0x13 from word 0x80FF0000 → signed gives 0xFFFFFF80; ld_unsigned gives 0x00000080. Load half @0x12 → 0xFFFF80FF signed.
- Store word @0x06, load half @0x03, size=11, and mem_read+mem_write together → each produces a 1-cycle fault pulse, no wb_valid, and memory unchanged (confirmed by a later read).
- MEM_DEPTH=4: store 0x5 @0x20, then load @0x00 → 0x5 (address wrap). Also run with MEM_LAT=1 and MEM_LAT=8 and check the exact latencies.
- Assert rst_n low one cycle after a load accept → no wb_valid after release. in_ready = 1 right after release. A new ALU op then completes normally.
